mem_port_arbiter: RTL and testbench

Shares one single-port synchronous data/instruction RAM between the core's instruction-fetch port and its load/store bus port, replacing clock-phase multiplexing with a cycle-based grant/response handshake. Sits between the core (fetch unit, memory bus master) and the RAM macro. Data accesses have priority; a streak counter bounds fetch starvation. The block registers the last fetched instruction so the fetch output stays stable between fetches.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the load/store bus.
// Data wins contention; a bounded data streak guarantees fetch progress.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 3,
    parameter int AW           = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [3:0]    d_mask,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [3:0]    mem_mask,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    owner_t        owner_reg;
    logic          d_read_reg;
    logic [3:0]    streak_reg;
    logic [3:0]    streak_next;
    logic [31:0]   if_rdata_reg;
    logic [AW-1:0] addr_hold_reg;
    logic          fetch_turn;

    // Fetch takes the port once data has won MAX_D_STREAK contended cycles in a row.
    assign fetch_turn = if_req && (streak_reg == MAX_STREAK);
    assign d_gnt      = rst && d_req && !fetch_turn;
    assign if_gnt     = rst && if_req && !d_gnt;

    always_comb begin
        streak_next = streak_reg;
        if (!if_req || if_gnt) begin
            streak_next = 4'd0;
        end else if (d_gnt && (streak_reg < MAX_STREAK)) begin
            streak_next = streak_reg + 4'd1;
        end
    end

    always_comb begin
        mem_addr  = addr_hold_reg;
        mem_we    = 1'b0;
        mem_mask  = 4'b0000;
        mem_wdata = 32'd0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_mask  = d_we ? d_mask : 4'b1111;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr = if_addr;
            mem_mask = 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg     <= OWN_NONE;
            d_read_reg    <= 1'b0;
            streak_reg    <= 4'd0;
            if_rdata_reg  <= 32'd0;
            addr_hold_reg <= '0;
        end else begin
            streak_reg <= streak_next;
            d_read_reg <= d_gnt && !d_we;
            if (d_gnt) begin
                owner_reg <= OWN_D;
            end else if (if_gnt) begin
                owner_reg <= OWN_IF;
            end else begin
                owner_reg <= OWN_NONE;
            end
            if (owner_reg == OWN_IF) begin
                if_rdata_reg <= mem_rdata;
            end
            if (d_gnt || if_gnt) begin
                addr_hold_reg <= mem_addr;
            end
        end
    end

    // The RAM word is forwarded during the response cycle, then held in if_rdata_reg.
    assign if_rvalid = (owner_reg == OWN_IF);
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_reg;
    assign d_rvalid  = (owner_reg == OWN_D);
    assign d_rdata   = (d_rvalid && d_read_reg) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter with a RAM model and
// a transaction-level reference model of arbitration and responses.
module tb_mem_port_arbiter;

    localparam int AW    = 14;
    localparam int MAXS  = 3;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic          d_we = 1'b0;
    logic [3:0]    d_mask = 4'b0;
    logic [31:0]   d_wdata = 32'd0;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [3:0]    mem_mask;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_mask(d_mask),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_mask(mem_mask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM macro: synchronous read, byte-masked write.
    logic [31:0] ram [0:WORDS-1];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]   model_mem [0:WORDS-1];
    int            m_streak = 0;
    logic          pend_if = 1'b0, pend_d = 1'b0;
    logic [31:0]   pend_if_data = 32'd0, pend_d_data = 32'd0;
    logic [31:0]   last_if_word = 32'd0;
    logic [AW-1:0] last_addr = '0;
    logic          addr_known = 1'b0;
    logic          last_gd = 1'b0, last_gi = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic ifr, input logic [AW-1:0] ifa,
                         input logic dr, input logic [AW-1:0] da, input logic dwe,
                         input logic [3:0] dm, input logic [31:0] dwd);
        logic       eg_d, eg_if;
        logic [3:0] em;
        logic [31:0] w;
        @(posedge clk);
        #1;
        chk("if_rvalid", 32'(if_rvalid), 32'(pend_if));
        if (pend_if) last_if_word = pend_if_data;
        chk("if_rdata", if_rdata, last_if_word);
        chk("d_rvalid", 32'(d_rvalid), 32'(pend_d));
        chk("d_rdata", d_rdata, pend_d ? pend_d_data : 32'd0);

        if_req = ifr; if_addr = ifa;
        d_req = dr; d_addr = da; d_we = dwe; d_mask = dm; d_wdata = dwd;
        #1;
        eg_d  = dr && !(ifr && (m_streak == MAXS));
        eg_if = ifr && !eg_d;
        em    = eg_d ? (dwe ? dm : 4'b1111) : (eg_if ? 4'b1111 : 4'b0000);
        chk("d_gnt", 32'(d_gnt), 32'(eg_d));
        chk("if_gnt", 32'(if_gnt), 32'(eg_if));
        chk("mem_we", 32'(mem_we), 32'(eg_d && dwe));
        chk("mem_mask", 32'(mem_mask), 32'(em));
        if (eg_d) chk("mem_addr", 32'(mem_addr), 32'(da));
        else if (eg_if) chk("mem_addr", 32'(mem_addr), 32'(ifa));
        else if (addr_known) chk("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
        if (eg_d && dwe) chk("mem_wdata", mem_wdata, dwd);
        $display("cyc t=%0t if_req=%0b d_req=%0b we=%0b gnt_if=%0b gnt_d=%0b addr=%h",
                 $time, ifr, dr, dwe, if_gnt, d_gnt, mem_addr);

        pend_if      = eg_if;
        pend_if_data = model_mem[ifa];
        pend_d       = eg_d;
        pend_d_data  = dwe ? 32'd0 : model_mem[da];
        if (eg_d && dwe) begin
            w = model_mem[da];
            for (int b = 0; b < 4; b++) if (dm[b]) w[8*b +: 8] = dwd[8*b +: 8];
            model_mem[da] = w;
        end
        if (eg_if || !ifr) m_streak = 0;
        else if (eg_d && m_streak < MAXS) m_streak++;
        if (eg_d) begin last_addr = da; addr_known = 1'b1; end
        else if (eg_if) begin last_addr = ifa; addr_known = 1'b1; end
        last_gd = eg_d;
        last_gi = eg_if;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 4'b0, 32'd0);
    endtask

    task automatic model_reset();
        pend_if = 1'b0; pend_d = 1'b0; last_if_word = 32'd0;
        m_streak = 0; addr_known = 1'b0;
    endtask

    logic [7:0] gseq;
    logic          ip, dp, rwe;
    logic [AW-1:0] ra, rd;
    logic [3:0]    rm;
    logic [31:0]   rw;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            model_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
            ram[i]      <= (i * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
        end
        model_mem[16'h010] = 32'h0000_0013; ram[16'h010] <= 32'h0000_0013;
        model_mem[16'h020] = 32'h1122_3344; ram[16'h020] <= 32'h1122_3344;

        // Reset state with requests pending: grants must stay low.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_mask = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_mask = 4'h0;
        @(negedge clk);
        rst = 1'b1;

        // Fetch only
        repeat (3) cycle(1'b1, 14'h010, 1'b0, '0, 1'b0, 4'b0, 32'd0);
        idle();
        chk("lit_fetch_word", if_rdata, 32'h0000_0013);

        // Partial write then read
        cycle(1'b0, '0, 1'b1, 14'h020, 1'b1, 4'b0011, 32'hAABB_CCDD);
        cycle(1'b0, '0, 1'b1, 14'h020, 1'b0, 4'b0000, 32'd0);
        chk("lit_wr_ack", 32'(d_rvalid), 32'd1);
        chk("lit_wr_rdata", d_rdata, 32'd0);
        idle();
        chk("lit_rd_word", d_rdata, 32'h1122_CCDD);

        // Write then fetch of the same word
        cycle(1'b0, '0, 1'b1, 14'h030, 1'b1, 4'b1111, 32'hCAFE_F00D);
        cycle(1'b1, 14'h030, 1'b0, '0, 1'b0, 4'b0, 32'd0);
        idle();
        chk("lit_wr_fetch", if_rdata, 32'hCAFE_F00D);

        // Contention for eight cycles
        gseq = 8'd0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 14'h010, 1'b1, 14'(64 + i), 1'b0, 4'b0, 32'd0);
            gseq = {gseq[6:0], last_gd};
        end
        chk("lit_contention_seq", 32'(gseq), 32'h0000_00EE);
        idle();

        // Fetch drops mid-streak: streak restarts
        gseq = 8'd0;
        cycle(1'b1, 14'h010, 1'b1, 14'h050, 1'b0, 4'b0, 32'd0); gseq = {gseq[6:0], last_gd};
        cycle(1'b1, 14'h010, 1'b1, 14'h051, 1'b0, 4'b0, 32'd0); gseq = {gseq[6:0], last_gd};
        cycle(1'b0, 14'h010, 1'b1, 14'h052, 1'b0, 4'b0, 32'd0); gseq = {gseq[6:0], last_gd};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 14'h010, 1'b1, 14'(83 + i), 1'b0, 4'b0, 32'd0);
            gseq = {gseq[6:0], last_gd};
        end
        chk("lit_drop_seq", 32'(gseq), 32'h0000_007E);

        // Idle
        repeat (5) idle();

        // Reset while a fetch response is visible and a data read is in flight
        cycle(1'b1, 14'h010, 1'b0, '0, 1'b0, 4'b0, 32'd0);
        cycle(1'b0, '0, 1'b1, 14'h020, 1'b0, 4'b0, 32'd0);
        rst = 1'b0;
        #1;
        chk("arst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("arst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("arst_if_rdata", if_rdata, 32'd0);
        chk("arst_d_gnt", 32'(d_gnt), 32'd0);
        chk("arst_mem_we", 32'(mem_we), 32'd0);
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) idle();

        // Randomised traffic with requesters that hold until granted or withdraw
        ip = 1'b0; dp = 1'b0; ra = '0; rd = '0; rwe = 1'b0; rm = 4'b0; rw = 32'd0;
        for (int n = 0; n < 600; n++) begin
            if (!ip && ($urandom_range(0, 2) != 0)) begin
                ip = 1'b1; ra = 14'($urandom_range(0, 31));
            end else if (ip && ($urandom_range(0, 15) == 0)) begin
                ip = 1'b0;
            end
            if (!dp && ($urandom_range(0, 2) != 0)) begin
                dp = 1'b1; rd = 14'($urandom_range(0, 31));
                rwe = 1'($urandom_range(0, 1)); rm = 4'($urandom_range(0, 15));
                rw = $urandom;
            end else if (dp && ($urandom_range(0, 15) == 0)) begin
                dp = 1'b0;
            end
            cycle(ip, ra, dp, rd, rwe, rm, rw);
            if (last_gi) ip = 1'b0;
            if (last_gd) dp = 1'b0;
        end
        repeat (2) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
